frame_tx_controller: RTL and testbench
======================================

Name: frame_tx_controller

Overview:
- Sequencing FSM for a serial frame transmitter built around the external 8-bit loadable down counter (ports parin_8_cnt, load, cnt_8_en, parout_8_cnt, cout).
- On a start request it loads the payload byte count N into the counter and sends an 8-bit header carrying N.
- It then fetches N payload bytes over a valid/ready handshake and shifts each one out MSB-first, decrementing the counter once per accepted byte.
- It sits between the upstream byte source and the serial line driver.

Parameters:
- DATA_W, 8, payload byte and header width in bits; fixed at 8, other values not supported.
- CNT_W, 8, byte-counter width; must match the counter instance.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset; shared with the counter instance.
- start  input  1  frame request; sampled only in IDLE.
- frame_len  input  CNT_W  payload byte count N (0..255); sampled with start.
- byte_data  input  DATA_W  payload byte from upstream.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  controller accepts byte_data this cycle.
- cnt_parin  output  CNT_W  drives counter parin_8_cnt; equals frame_len.
- cnt_load  output  1  drives counter load.
- cnt_en  output  1  drives counter cnt_8_en.
- cnt_cout  input  1  counter cout, i.e. count==0 and enable low.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of frame.

Behaviour:
- States: IDLE, HEADER, FETCH, SHIFT, DONE.
- Internal 3-bit bit counter; 8-bit shift register.
- Reset (async, any state): state=IDLE, bit counter=0, shift register=0.
  - All outputs low: byte_ready, cnt_load, cnt_en, ser_out, ser_valid, busy, done.
  - Reset mid-frame aborts the frame with no done pulse.
- IDLE:
  - cnt_load = start (Mealy, same cycle).
  - On start: shift register <= frame_len, bit counter <= 0, next state HEADER.
- HEADER (8 cycles):
  - ser_valid=1; ser_out = shift register MSB.
  - Shift left each cycle; bit counter increments.
  - On bit counter==7, go to DONE if cnt_cout=1 (N=0), else FETCH.
- FETCH:
  - byte_ready=1; ser_valid=0; ser_out=0.
  - If byte_valid: cnt_en=1 for exactly this cycle (Mealy), shift register <= byte_data, bit counter <= 0, next state SHIFT.
  - Otherwise remain in FETCH indefinitely. There is no timeout.
- SHIFT (8 cycles):
  - Same serialisation as HEADER.
  - On bit 7, go to DONE if cnt_cout=1, else FETCH.
  - The counter decremented in the FETCH cycle is settled and cnt_en is low by this point, so cnt_cout is valid.
- DONE:
  - done=1 for one cycle; next state IDLE.
  - busy=0 starts the following cycle.
- cnt_parin = frame_len combinationally at all times.
- cnt_load and cnt_en are never high together.
- start is ignored whenever state != IDLE; no queuing.
- byte_valid outside FETCH is ignored; byte_ready is never high outside FETCH.
- Frame length in cycles: 1 (start) + 8 + N*(8 + fetch wait ≥ 1) + 1 (DONE).
- Minimum gap between frames: start is accepted the cycle after DONE.

Test Plan:
- Zero-length frame:
  - Stimulus: rst pulse, then start=1 with frame_len=0 at cycle 0.
  - Required: cnt_load=1 at cycle 0; ser_out=00000000 with ser_valid=1 at cycles 1-8; done=1 at cycle 9; byte_ready never asserted; busy=0 from cycle 10.
- Two bytes, source always valid:
  - Stimulus: frame_len=2; byte_data=8'hA5, then 8'h3C.
  - Required: header 00000010 at cycles 1-8.
  - Cycle 9: byte_ready=1 and cnt_en=1; cycles 10-17 output 10100101.
  - Cycle 18: second fetch; cycles 19-26 output 00111100.
  - Cycle 27: done=1; counter reads 0.
- Stalled source:
  - Stimulus: frame_len=1; byte_valid low for 5 cycles after entering FETCH.
  - Required: byte_ready held high; ser_valid=0 and cnt_en=0 throughout the stall; byte is accepted on the first valid cycle; done asserts 9 cycles later.
- Start while busy:
  - Stimulus: start=1 pulsed during HEADER and during SHIFT.
  - Required: no cnt_load; frame and counter are unaffected; done count = 1.
- Reset mid-frame:
  - Stimulus: frame_len=3; assert rst asynchronously (off clock edge) during the second SHIFT.
  - Required: immediately busy=0 and ser_valid=0; no done pulse; a new start with frame_len=1 completes normally.
- Maximum length:
  - Stimulus: frame_len=255; source always valid.
  - Required: exactly 255 cnt_en pulses; header 11111111; done at cycle 1+8+255*9=2304.

Source files
------------

// File: rtl/frame_tx_controller.sv
// Frame transmitter sequencer: header byte carrying N, then N payload
// bytes shifted out MSB-first, with an external byte down counter.
module frame_tx_controller #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [CNT_W-1:0]  cnt_parin,
  output logic              cnt_load,
  output logic              cnt_en,
  input  logic              cnt_cout,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  logic ser_out_q, ser_out_d;
  logic ser_valid_q, ser_valid_d;
  logic byte_ready_q, byte_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic last_bit;

  assign last_bit  = (bit_q == 3'd7);
  assign cnt_parin = frame_len;

  // Next-state, datapath and the two same-cycle counter strobes.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_load = start;
        if (start) begin
          shreg_d = DATA_W'(frame_len);
          bit_d   = 3'd0;
          state_d = S_HEADER;
        end
      end
      S_HEADER, S_SHIFT: begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        bit_d   = bit_q + 3'd1;
        if (last_bit) begin
          state_d = cnt_cout ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (byte_valid) begin
          cnt_en  = 1'b1;
          shreg_d = byte_data;
          bit_d   = 3'd0;
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs precomputed from the next state so they leave a flop.
  always_comb begin
    ser_valid_d  = (state_d == S_HEADER) ||
                   (state_d == S_SHIFT);
    ser_out_d    = ser_valid_d & shreg_d[DATA_W-1];
    byte_ready_d = (state_d == S_FETCH);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_q        <= 3'd0;
      shreg_q      <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign byte_ready = byte_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_frame_tx_controller.sv
// Bench for frame_tx_controller: frames are planned as a per-cycle
// timeline of stimulus and expected outputs, then replayed and checked.
`timescale 1ns/1ps
module tb_frame_tx_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] frame_len;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] cnt_parin;
  logic       cnt_load;
  logic       cnt_en;
  logic       cnt_cout;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;

  logic [7:0] cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       start;
    logic [7:0] flen;
    logic       valid;
    logic [7:0] data;
    logic       rdy;
    logic       sv;
    logic       so;
    logic       en;
    logic       ld;
    logic       busy;
    logic       done;
  } cyc_t;

  cyc_t       tl[$];
  logic [7:0] bytes_q[$];
  int         stall_q[$];

  frame_tx_controller #(.DATA_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_len  (frame_len),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .cnt_parin  (cnt_parin),
    .cnt_load   (cnt_load),
    .cnt_en     (cnt_en),
    .cnt_cout   (cnt_cout),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // External 8-bit loadable down counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= 8'd0;
    else if (cnt_load) cnt <= cnt_parin;
    else if (cnt_en)   cnt <= cnt - 8'd1;
  end
  assign cnt_cout = (cnt == 8'd0) && !cnt_en;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plan one frame: 1 start cycle, 8 header bits, per byte
  // (stall + accept + 8 bits), 1 done cycle, 2 idle cycles.
  task automatic build(input int n, input bit rnd);
    cyc_t       c;
    logic [7:0] b;
    int         s, a, e;
    while (bytes_q.size() < n) bytes_q.push_back(8'($urandom));
    while (stall_q.size() < n)
      stall_q.push_back(rnd ? int'($urandom_range(0, 4)) : 0);
    tl.delete();
    c = '0; c.start = 1'b1; c.flen = 8'(n); c.ld = 1'b1;
    tl.push_back(c);
    b = 8'(n);
    for (int k = 7; k >= 0; k--) begin
      c = '0; c.busy = 1'b1; c.sv = 1'b1; c.so = b[k];
      tl.push_back(c);
    end
    for (int i = 0; i < n; i++) begin
      b = bytes_q[i];
      s = stall_q[i];
      for (int k = 0; k < s; k++) begin
        c = '0; c.busy = 1'b1; c.rdy = 1'b1;
        c.data = 8'($urandom);
        tl.push_back(c);
      end
      c = '0; c.busy = 1'b1; c.rdy = 1'b1; c.en = 1'b1;
      c.valid = 1'b1; c.data = b;
      tl.push_back(c);
      a = tl.size() - 1;
      e = (rnd && s == 0) ? int'($urandom_range(0, 7)) : 0;
      for (int j = 1; j <= e; j++) begin
        tl[a-j].valid = 1'b1;
        tl[a-j].data  = b;
      end
      for (int k = 7; k >= 0; k--) begin
        c = '0; c.busy = 1'b1; c.sv = 1'b1; c.so = b[k];
        tl.push_back(c);
      end
    end
    c = '0; c.busy = 1'b1; c.done = 1'b1;
    tl.push_back(c);
    c = '0; tl.push_back(c);
    c = '0; tl.push_back(c);
    for (int t = 1; t < tl.size() - 2; t++) begin
      tl[t].flen = 8'($urandom);
      if (rnd && ($urandom % 8 == 0)) tl[t].start = 1'b1;
    end
    bytes_q.delete();
    stall_q.delete();
  endtask

  // Replay up to lim cycles of the plan, checking every cycle.
  task automatic run(input int lim);
    for (int t = 0; t < lim && t < tl.size(); t++) begin
      @(negedge clk);
      start      = tl[t].start;
      frame_len  = tl[t].flen;
      byte_valid = tl[t].valid;
      byte_data  = tl[t].data;
      #1;
      chk($sformatf("byte_ready t=%0d", t), 32'(byte_ready), 32'(tl[t].rdy));
      chk($sformatf("ser_valid t=%0d", t), 32'(ser_valid), 32'(tl[t].sv));
      if (tl[t].sv || tl[t].rdy)
        chk($sformatf("ser_out t=%0d", t), 32'(ser_out), 32'(tl[t].so));
      chk($sformatf("cnt_en t=%0d", t), 32'(cnt_en), 32'(tl[t].en));
      chk($sformatf("cnt_load t=%0d", t), 32'(cnt_load), 32'(tl[t].ld));
      chk($sformatf("busy t=%0d", t), 32'(busy), 32'(tl[t].busy));
      chk($sformatf("done t=%0d", t), 32'(done), 32'(tl[t].done));
      chk($sformatf("cnt_parin t=%0d", t), 32'(cnt_parin), 32'(tl[t].flen));
      if (tl[t].done)
        chk($sformatf("cnt_at_done t=%0d", t), 32'(cnt), 32'd0);
    end
    start      = 1'b0;
    byte_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    frame_len  = 8'd0;
    byte_data  = 8'd0;
    byte_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst byte_ready", 32'(byte_ready), 32'd0);
    chk("rst cnt_load", 32'(cnt_load), 32'd0);
    chk("rst cnt_en", 32'(cnt_en), 32'd0);
    chk("rst ser_out", 32'(ser_out), 32'd0);
    chk("rst ser_valid", 32'(ser_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // zero-length frame
    build(0, 1'b0);
    run(tl.size());

    // two bytes, source always valid
    bytes_q = '{8'hA5, 8'h3C};
    stall_q = '{0, 0};
    build(2, 1'b0);
    run(tl.size());

    // stalled source
    bytes_q = '{8'h5A};
    stall_q = '{5};
    build(1, 1'b0);
    run(tl.size());

    // start pulses during HEADER and SHIFT
    stall_q = '{0, 0};
    build(2, 1'b0);
    tl[3].start  = 1'b1;
    tl[3].flen   = 8'h77;
    tl[12].start = 1'b1;
    tl[12].flen  = 8'h09;
    run(tl.size());

    // reset during the second SHIFT
    stall_q = '{0, 0, 0};
    build(3, 1'b0);
    run(22);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst ser_valid", 32'(ser_valid), 32'd0);
    chk("midrst byte_ready", 32'(byte_ready), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("midrst no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    build(1, 1'b0);
    run(tl.size());

    // maximum length
    build(255, 1'b0);
    run(tl.size());

    // randomized frames with stalls, early valids and start noise
    for (int f = 0; f < 6; f++) begin
      build(int'($urandom_range(1, 12)), 1'b1);
      run(tl.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
